// File: rtl/addertree_final.sv
// Final stage of a carry-save adder tree: resolves the two rows, then rounds,
// shifts, applies optional ReLU and saturates into a signed output with backpressure.
module addertree_final #(
    parameter int W     = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum_a,
    input  logic [W-1:0]     sum_b,
    input  logic             relu_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      sat_cnt
);

    localparam logic signed [W:0] C_RND = (W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [W:0] C_MAX = (W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [W:0] C_MIN = ~C_MAX;

    logic [W-1:0]        r_s1_sum;
    logic                r_s1_relu;
    logic                r_s1_valid;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic                r_out_sat;
    logic [15:0]         r_sat_cnt;

    logic                w_s2_load;
    logic                w_s1_load;
    logic signed [W:0]   w_ext;
    logic signed [W:0]   w_rnd;
    logic signed [W:0]   w_r;
    logic [OUT_W-1:0]    w_res;
    logic                w_sat;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

    // One guard bit above the wrapped sum keeps the rounding add from overflowing.
    assign w_ext = $signed({r_s1_sum[W-1], r_s1_sum});
    assign w_rnd = w_ext + C_RND;
    assign w_r   = w_rnd >>> SHIFT;

    always_comb begin
        w_res = w_r[OUT_W-1:0];
        w_sat = 1'b0;
        if (r_s1_relu && (w_r < 0)) begin
            w_res = '0;
        end else if (w_r > C_MAX) begin
            w_res = C_MAX[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_r < C_MIN) begin
            w_res = C_MIN[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_relu  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum  <= sum_a + sum_b;
                r_s1_relu <= relu_en;
            end
        end
    end

    // A bubble in stage 1 clears out_valid but leaves the last data in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_sat  <= w_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_sat) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_addertree_final.sv
// Directed bench for addertree_final: vector table for the arithmetic, plus
// hand-written sequences for backpressure, mid-flight reset and counter wrap.
module tb_addertree_final;

    localparam int W     = 20;
    localparam int OUT_W = 8;
    localparam int SHIFT = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     sum_a = '0;
    logic [W-1:0]     sum_b = '0;
    logic             relu_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic [15:0]      sat_cnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] expSat = '0;

    always #5 clk = ~clk;

    addertree_final #(.W(W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_a     (sum_a),
        .sum_b     (sum_b),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt)
    );

    typedef struct {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic             relu;
        logic [OUT_W-1:0] data;
        logic             sat;
        string            name;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic r);
        in_valid = v;
        sum_a    = a;
        sum_b    = b;
        relu_en  = r;
    endtask

    // Single beat through an idle pipeline; output must appear exactly two edges later.
    task automatic runVector(input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(1'b1, v.a, v.b, v.relu);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput({v.name, "_early"}, out_valid, 0);
        @(negedge clk);
        checkOutput({v.name, "_valid"}, out_valid, 1);
        checkOutput({v.name, "_data"}, out_data, v.data);
        checkOutput({v.name, "_sat"}, out_sat, v.sat);
        if (v.sat) expSat++;
        @(negedge clk);
        checkOutput({v.name, "_drain"}, out_valid, 0);
        checkOutput({v.name, "_satcnt"}, sat_cnt, expSat);
    endtask

    initial begin
        int acc;
        int got;
        int hs;
        logic doneMid;

        vecs[0]  = '{20'h00100, 20'h00040, 1'b0, 8'h03, 1'b0, "basic"};
        vecs[1]  = '{20'hFFC18, 20'h00000, 1'b0, 8'hF8, 1'b0, "neg_floor"};
        vecs[2]  = '{20'hFFC18, 20'h00000, 1'b1, 8'h00, 1'b0, "neg_relu"};
        vecs[3]  = '{20'h40000, 20'h00000, 1'b0, 8'h7F, 1'b1, "sat_pos"};
        vecs[4]  = '{20'h7FFFF, 20'h00001, 1'b0, 8'h80, 1'b1, "sat_wrap"};
        vecs[5]  = '{20'h00040, 20'h00000, 1'b0, 8'h01, 1'b0, "round_up"};
        vecs[6]  = '{20'h0003F, 20'h00000, 1'b0, 8'h00, 1'b0, "round_down"};
        vecs[7]  = '{20'hFFFBF, 20'h00000, 1'b0, 8'hFF, 1'b0, "neg_one"};
        vecs[8]  = '{20'h03F80, 20'h00000, 1'b0, 8'h7F, 1'b0, "max_exact"};
        vecs[9]  = '{20'h02000, 20'h02000, 1'b0, 8'h7F, 1'b1, "max_plus1"};
        vecs[10] = '{20'hFBF80, 20'h00000, 1'b0, 8'h80, 1'b1, "min_minus1"};
        vecs[11] = '{20'hFBF80, 20'h00000, 1'b1, 8'h00, 1'b0, "relu_negsat"};

        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_sat", out_sat, 0);
        checkOutput("reset_sat_cnt", sat_cnt, 0);
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) runVector(vecs[i]);

        // Stall the output for three cycles while a five-beat stream is offered.
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 4);
            applyStimulus(acc < 5, W'((acc + 1) << SHIFT), '0, 1'b0);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checkOutput($sformatf("bp_in_ready_c%0d", cyc), in_ready, 0);
                checkOutput($sformatf("bp_hold_valid_c%0d", cyc), out_valid, 1);
                checkOutput($sformatf("bp_hold_data_c%0d", cyc), out_data, 1);
            end
            if (out_valid && out_ready) begin
                got++;
                checkOutput($sformatf("bp_order_%0d", got), out_data, got);
            end
            if (in_valid && in_ready) acc++;
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        checkOutput("bp_count", got, 5);
        @(negedge clk);
        checkOutput("bp_no_dup", out_valid, 0);

        // Two beats in flight, then reset.
        @(negedge clk);
        applyStimulus(1'b1, W'(1 << SHIFT), '0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, W'(2 << SHIFT), '0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("rst_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_sat_cnt", sat_cnt, 0);
        expSat = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rst_no_stale_%0d", k), out_valid, 0);
            @(negedge clk);
        end
        runVector(vecs[0]);

        // Drive 65536 saturating handshakes so the counter wraps back to zero.
        hs = 0;
        acc = 0;
        doneMid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70000 && hs < 65536; cyc++) begin
            @(negedge clk);
            if (hs == 65535 && !doneMid) begin
                checkOutput("wrap_ffff", sat_cnt, 16'hFFFF);
                doneMid = 1'b1;
            end
            applyStimulus(acc < 65536, 20'h40000, '0, 1'b0);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready && out_sat) begin
                hs++;
                expSat++;
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("wrap_handshakes", hs, 65536);
        @(negedge clk);
        checkOutput("wrap_zero", sat_cnt, 16'h0000);
        checkOutput("wrap_model", sat_cnt, expSat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
